// File: rtl/mha_head_scheduler_pkg.sv
// Shared types and helpers for the multi-head attention scheduler.
//  - state_e      : scheduler FSM states
//  - Addr*        : slot indices of the per-head engine address bank
//  - Default*     : default attention dimensions (sequence length, embedding, head width)
//  - *_stride()   : per-head byte strides of the weight and activation buffers
package mha_head_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StNext,
    StFinish
  } state_e;

  localparam int unsigned DefaultTokens  = 128;
  localparam int unsigned DefaultEmbed   = 768;
  localparam int unsigned DefaultHeadDim = 64;

  // Engine address slots.
  localparam int unsigned NumAddr = 10;
  localparam int AddrI   = 0;  // input matrix, shared
  localparam int AddrWq  = 1;
  localparam int AddrWk  = 2;
  localparam int AddrWv  = 3;
  localparam int AddrQp  = 4;
  localparam int AddrKpt = 5;
  localparam int AddrVp  = 6;
  localparam int AddrS   = 7;  // scratch, shared
  localparam int AddrP   = 8;  // scratch, shared
  localparam int AddrCp  = 9;

  function automatic int unsigned w_stride(input int unsigned embed, input int unsigned head_dim);
    return embed * head_dim;
  endfunction

  function automatic int unsigned qkv_stride(input int unsigned tokens,
                                             input int unsigned head_dim);
    return tokens * head_dim;
  endfunction

  // Per-head increment of one address slot; shared buffers do not move.
  function automatic int unsigned slot_stride(input int slot, input int unsigned w,
                                              input int unsigned qkv, input int unsigned c);
    case (slot)
      AddrWq, AddrWk, AddrWv:  return w;
      AddrQp, AddrKpt, AddrVp: return qkv;
      AddrCp:                  return c;
      default:                 return 0;
    endcase
  endfunction

endpackage

// File: rtl/mha_head_scheduler_if.sv
// Scheduler <-> single-head attention engine link.
//  start           : one-cycle launch pulse (scheduler -> engine)
//  done, error     : completion pulse and error flag sampled with it (engine -> scheduler)
//  addr_*          : per-head DDR addresses (scheduler -> engine)
// Modports: master = scheduler side, slave = engine side.
interface mha_head_scheduler_if #(
  parameter int unsigned AddrWidth = 64
);
  logic                 start;
  logic                 done;
  logic                 error;
  logic [AddrWidth-1:0] addr_i;
  logic [AddrWidth-1:0] addr_w_q;
  logic [AddrWidth-1:0] addr_w_k;
  logic [AddrWidth-1:0] addr_w_v;
  logic [AddrWidth-1:0] addr_q_prime;
  logic [AddrWidth-1:0] addr_k_prime_t;
  logic [AddrWidth-1:0] addr_v_prime;
  logic [AddrWidth-1:0] addr_s;
  logic [AddrWidth-1:0] addr_p;
  logic [AddrWidth-1:0] addr_c_prime;

  modport master (
    output start, addr_i, addr_w_q, addr_w_k, addr_w_v, addr_q_prime, addr_k_prime_t,
           addr_v_prime, addr_s, addr_p, addr_c_prime,
    input  done, error
  );

  modport slave (
    input  start, addr_i, addr_w_q, addr_w_k, addr_w_v, addr_q_prime, addr_k_prime_t,
           addr_v_prime, addr_s, addr_p, addr_c_prime,
    output done, error
  );
endinterface

// File: rtl/mha_head_scheduler_addr_gen.sv
// Per-head engine address bank.
//  clk, rstn : clock, synchronous active-low reset (bank clears to zero)
//  load      : copy base[] into the bank (head 0)
//  advance   : add each slot's per-head stride (wraps modulo 2**AddrWidth)
//  base      : head-0 addresses, indexed by the package Addr* slots
//  addr      : registered addresses of the current head
module mha_head_scheduler_addr_gen
  import mha_head_scheduler_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned WStride   = 1,
  parameter int unsigned QkvStride = 1,
  parameter int unsigned CStride   = 1
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                load,
  input  logic                                advance,
  input  logic [NumAddr-1:0][AddrWidth-1:0]   base,
  output logic [NumAddr-1:0][AddrWidth-1:0]   addr
);

  logic [NumAddr-1:0][AddrWidth-1:0] addr_q;
  logic [NumAddr-1:0][AddrWidth-1:0] step;

  always_comb begin
    step = '0;
    for (int i = 0; i < NumAddr; i++) begin
      step[i] = AddrWidth'(slot_stride(i, WStride, QkvStride, CStride));
    end
  end

  // Accumulate instead of multiplying by the head index.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q <= '0;
    end else if (load) begin
      addr_q <= base;
    end else if (advance) begin
      for (int i = 0; i < NumAddr; i++) begin
        addr_q[i] <= addr_q[i] + step[i];
      end
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/mha_head_scheduler.sv
// Multi-head sequencer in front of the single-head self-attention engine. Runs the engine once
// per head (0..n-1, n = min(head_count, NumHeads)), moving the weight/projection/context
// addresses by one head stride between launches, and reports completion and the failing head.
// Requant/softmax parameters do not pass through here. The engine must share rstn so that a
// reset mid-run aborts both sides together.
// Optional feature: define MHA_TIMEOUT_EN for a per-head watchdog of TimeoutCycles cycles.
// Ports:
//  clk, rstn        : clock, synchronous active-low reset
//  start            : one-cycle run request, ignored while busy
//  head_count       : heads to run, sampled on an accepted start
//  addr_*           : head-0 base addresses (I, S, P shared by all heads)
//  busy             : run in progress
//  done, error      : run finished (level) / run failed, valid while done
//  err_head         : failing head index, valid while error
//  cur_head         : head currently dispatched
//  eng              : engine link (launch pulse, completion, per-head addresses)
module mha_head_scheduler
  import mha_head_scheduler_pkg::*;
#(
  parameter int unsigned NumHeads     = 12,
  parameter int unsigned Tokens       = DefaultTokens,
  parameter int unsigned Embed        = DefaultEmbed,
  parameter int unsigned HeadDim      = DefaultHeadDim,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned HeadW        = $clog2(NumHeads + 1)
`ifdef MHA_TIMEOUT_EN
  ,
  parameter int unsigned TimeoutCycles = 2 ** 24
`endif
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [HeadW-1:0]        head_count,
  input  logic [AxiAddrWidth-1:0] addr_i,
  input  logic [AxiAddrWidth-1:0] addr_w_q,
  input  logic [AxiAddrWidth-1:0] addr_w_k,
  input  logic [AxiAddrWidth-1:0] addr_w_v,
  input  logic [AxiAddrWidth-1:0] addr_q_prime,
  input  logic [AxiAddrWidth-1:0] addr_k_prime_t,
  input  logic [AxiAddrWidth-1:0] addr_v_prime,
  input  logic [AxiAddrWidth-1:0] addr_s,
  input  logic [AxiAddrWidth-1:0] addr_p,
  input  logic [AxiAddrWidth-1:0] addr_c_prime,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [HeadW-1:0]        err_head,
  output logic [HeadW-1:0]        cur_head,
  mha_head_scheduler_if.master    eng
);

  localparam int unsigned WStride   = w_stride(Embed, HeadDim);
  localparam int unsigned QkvStride = qkv_stride(Tokens, HeadDim);
  localparam int unsigned CStride   = QkvStride;

  state_e           state_q, state_d;
  logic [HeadW-1:0] n_q, n_d;
  logic [HeadW-1:0] cur_head_q, cur_head_d;
  logic [HeadW-1:0] err_head_q, err_head_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             eng_start_q, eng_start_d;
  logic             addr_load, addr_advance;
  logic [HeadW-1:0] n_clamped;

  logic [NumAddr-1:0][AxiAddrWidth-1:0] base, addr;

`ifdef MHA_TIMEOUT_EN
  localparam int unsigned CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  assign n_clamped = (head_count > HeadW'(NumHeads)) ? HeadW'(NumHeads) : head_count;

  always_comb begin
    base         = '0;
    base[AddrI]  = addr_i;
    base[AddrWq] = addr_w_q;
    base[AddrWk] = addr_w_k;
    base[AddrWv] = addr_w_v;
    base[AddrQp] = addr_q_prime;
    base[AddrKpt] = addr_k_prime_t;
    base[AddrVp] = addr_v_prime;
    base[AddrS]  = addr_s;
    base[AddrP]  = addr_p;
    base[AddrCp] = addr_c_prime;
  end

  mha_head_scheduler_addr_gen #(
    .AddrWidth (AxiAddrWidth),
    .WStride   (WStride),
    .QkvStride (QkvStride),
    .CStride   (CStride)
  ) u_addr_gen (
    .clk     (clk),
    .rstn    (rstn),
    .load    (addr_load),
    .advance (addr_advance),
    .base    (base),
    .addr    (addr)
  );

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    cur_head_d   = cur_head_q;
    err_head_d   = err_head_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    eng_start_d  = 1'b0;
    addr_load    = 1'b0;
    addr_advance = 1'b0;
`ifdef MHA_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_d        = n_clamped;
          cur_head_d = '0;
          err_head_d = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          busy_d     = 1'b1;
          if (n_clamped == '0) begin
            state_d = StFinish;
          end else begin
            addr_load = 1'b1;
            state_d   = StLaunch;
          end
        end
      end
      StLaunch: begin
        // Registered pulse: visible in the first WAIT cycle, two cycles after start.
        eng_start_d = 1'b1;
`ifdef MHA_TIMEOUT_EN
        cnt_d       = '0;
`endif
        state_d     = StWait;
      end
      StWait: begin
        if (eng.done) begin
          if (eng.error) begin
            error_d    = 1'b1;
            err_head_d = cur_head_q;
            state_d    = StFinish;
          end else begin
            state_d = StNext;
          end
        end
`ifdef MHA_TIMEOUT_EN
        else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          error_d    = 1'b1;
          err_head_d = cur_head_q;
          state_d    = StFinish;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StNext: begin
        cur_head_d = cur_head_q + 1'b1;
        if (cur_head_d == n_q) begin
          state_d = StFinish;
        end else begin
          addr_advance = 1'b1;
          state_d      = StLaunch;
        end
      end
      StFinish: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      n_q         <= '0;
      cur_head_q  <= '0;
      err_head_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      eng_start_q <= 1'b0;
`ifdef MHA_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      cur_head_q  <= cur_head_d;
      err_head_q  <= err_head_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      eng_start_q <= eng_start_d;
`ifdef MHA_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign err_head = err_head_q;
  assign cur_head = cur_head_q;

  assign eng.start          = eng_start_q;
  assign eng.addr_i         = addr[AddrI];
  assign eng.addr_w_q       = addr[AddrWq];
  assign eng.addr_w_k       = addr[AddrWk];
  assign eng.addr_w_v       = addr[AddrWv];
  assign eng.addr_q_prime   = addr[AddrQp];
  assign eng.addr_k_prime_t = addr[AddrKpt];
  assign eng.addr_v_prime   = addr[AddrVp];
  assign eng.addr_s         = addr[AddrS];
  assign eng.addr_p         = addr[AddrP];
  assign eng.addr_c_prime   = addr[AddrCp];

endmodule

// File: tb/tb_mha_head_scheduler.sv
// Bench for mha_head_scheduler: table of runs with hand-computed outcomes, randomized runs
// scored by a small outcome model, plus reset-mid-run and (with MHA_TIMEOUT_EN) watchdog cases.
module tb_mha_head_scheduler;

  localparam int unsigned NumHeads = 12;
  localparam int unsigned Tokens   = 16;
  localparam int unsigned Embed    = 64;
  localparam int unsigned HeadDim  = 8;
  localparam int unsigned AW       = 64;
  localparam int unsigned HeadW    = $clog2(NumHeads + 1);
  localparam int          Limit    = 400;
`ifdef MHA_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = 64;
`endif
  localparam logic [AW-1:0] WStr   = AW'(Embed * HeadDim);
  localparam logic [AW-1:0] QkvStr = AW'(Tokens * HeadDim);

  typedef struct {
    int hc;
    int err_at;        // head that reports an error, -1 for none
    int lat;           // engine done latency after eng_start
    int poke;          // cycle of an extra start pulse during the run, -1 for none
    int exp_launches;
    int exp_err;
    int exp_eh;
  } vec_t;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [HeadW-1:0] head_count = '0;
  logic [AW-1:0]    base [10];
  logic [AW-1:0]    step [10];
  logic             busy, done, error;
  logic [HeadW-1:0] err_head, cur_head;

  int errors = 0;
  int checks = 0;

  mha_head_scheduler_if #(.AddrWidth(AW)) eng_if ();

  mha_head_scheduler #(
    .NumHeads     (NumHeads),
    .Tokens       (Tokens),
    .Embed        (Embed),
    .HeadDim      (HeadDim),
    .AxiAddrWidth (AW)
`ifdef MHA_TIMEOUT_EN
    ,
    .TimeoutCycles (TimeoutCycles)
`endif
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .head_count     (head_count),
    .addr_i         (base[0]),
    .addr_w_q       (base[1]),
    .addr_w_k       (base[2]),
    .addr_w_v       (base[3]),
    .addr_q_prime   (base[4]),
    .addr_k_prime_t (base[5]),
    .addr_v_prime   (base[6]),
    .addr_s         (base[7]),
    .addr_p         (base[8]),
    .addr_c_prime   (base[9]),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .err_head       (err_head),
    .cur_head       (cur_head),
    .eng            (eng_if)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] eng_addr(input int slot);
    case (slot)
      0:       return eng_if.addr_i;
      1:       return eng_if.addr_w_q;
      2:       return eng_if.addr_w_k;
      3:       return eng_if.addr_w_v;
      4:       return eng_if.addr_q_prime;
      5:       return eng_if.addr_k_prime_t;
      6:       return eng_if.addr_v_prime;
      7:       return eng_if.addr_s;
      8:       return eng_if.addr_p;
      default: return eng_if.addr_c_prime;
    endcase
  endfunction

  // Outcome of a run from the rules: clamp, stop at the first failing head.
  function automatic vec_t model(input int hc, input int err_at, input int lat, input int poke);
    vec_t v;
    int   n;
    n = (hc > int'(NumHeads)) ? int'(NumHeads) : hc;
    v = '{hc, err_at, lat, poke, n, 0, 0};
    if (err_at >= 0 && err_at < n) begin
      v.exp_launches = err_at + 1;
      v.exp_err      = 1;
      v.exp_eh       = err_at;
    end
    return v;
  endfunction

  task automatic set_bases();
    for (int i = 0; i < 10; i++) begin
      base[i] = {$urandom, $urandom};
    end
    // Near the top of the address space so per-head sums wrap.
    base[1][63:12] = '1;
    base[9][63:12] = '1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_err_head"}, 64'(err_head), 64'd0);
    check({tag, "_cur_head"}, 64'(cur_head), 64'd0);
    check({tag, "_eng_start"}, 64'(eng_if.start), 64'd0);
    for (int s = 0; s < 10; s++) begin
      check($sformatf("%s_addr%0d", tag, s), eng_addr(s), 64'd0);
    end
  endtask

  task automatic run_case(input string tag, input vec_t v);
    int launches = 0;
    int cd = 0;
    int cyc;
    set_bases();
    head_count = HeadW'(v.hc);
    start = 1'b1;
    @(posedge clk); #1;
    cyc   = 1;
    start = 1'b0;
    check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    check({tag, "_done_cleared"}, 64'(done), 64'd0);
    while (!done && cyc < Limit) begin
      if (cyc == v.poke) begin
        start      = 1'b1;
        head_count = HeadW'(1);
      end
      @(posedge clk); #1;
      cyc++;
      start         = 1'b0;
      eng_if.done   = 1'b0;
      eng_if.error  = 1'b0;
      if (eng_if.start) begin
        if (launches == 0) check({tag, "_first_launch_cycle"}, 64'(cyc), 64'd2);
        for (int s = 0; s < 10; s++) begin
          check($sformatf("%s_h%0d_addr%0d", tag, launches, s), eng_addr(s),
                base[s] + AW'(launches) * step[s]);
        end
        launches++;
        cd = v.lat;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          eng_if.done  = 1'b1;
          eng_if.error = (launches - 1 == v.err_at);
        end
      end
    end
    eng_if.done  = 1'b0;
    eng_if.error = 1'b0;
    check({tag, "_done_reached"}, 64'(done), 64'd1);
    if (v.exp_launches == 0) check({tag, "_empty_done_cycle"}, 64'(cyc), 64'd2);
    check({tag, "_launches"}, 64'(launches), 64'(v.exp_launches));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_error"}, 64'(error), 64'(v.exp_err));
    if (v.exp_err != 0) check({tag, "_err_head"}, 64'(err_head), 64'(v.exp_eh));
    @(posedge clk); #1;
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_done"}, 64'(done), 64'd1);
    check({tag, "_idle_eng_start"}, 64'(eng_if.start), 64'd0);
  endtask

  task automatic reset_mid_run();
    int starts = 0;
    int cd = 0;
    int cyc = 0;
    set_bases();
    head_count = HeadW'(3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (starts < 2 && cyc < Limit) begin
      @(posedge clk); #1;
      cyc++;
      eng_if.done = 1'b0;
      if (eng_if.start) begin
        starts++;
        cd = 3;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) eng_if.done = 1'b1;
      end
    end
    eng_if.done = 1'b0;
    check("rst_mid_second_launch", 64'(starts), 64'd2);
    @(posedge clk); #1;
    check("rst_mid_cur_head", 64'(cur_head), 64'd1);
    check("rst_mid_busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check_reset("rst_mid");
    rstn = 1'b1;
    run_case("after_rst", model(2, -1, 4, -1));
  endtask

`ifdef MHA_TIMEOUT_EN
  task automatic timeout_case();
    int cyc = 0;
    int t_start = -1;
    set_bases();
    head_count = HeadW'(2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!error && cyc < Limit) begin
      @(posedge clk); #1;
      cyc++;
      if (eng_if.start) t_start = cyc;
    end
    check("timeout_error", 64'(error), 64'd1);
    check("timeout_latency", 64'(cyc - t_start), 64'(TimeoutCycles));
    check("timeout_err_head", 64'(err_head), 64'd0);
    @(posedge clk); #1;
    check("timeout_done", 64'(done), 64'd1);
  endtask
`endif

  initial begin
    vec_t vecs[$];
    eng_if.done  = 1'b0;
    eng_if.error = 1'b0;
    step = '{64'd0, WStr, WStr, WStr, QkvStr, QkvStr, QkvStr, 64'd0, 64'd0, QkvStr};
    for (int i = 0; i < 10; i++) base[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rstn = 1'b1;

    //             hc  err lat poke launches err eh
    vecs.push_back('{3,  -1, 10, -1, 3,  0, 0});
    vecs.push_back('{0,  -1,  1, -1, 0,  0, 0});
    vecs.push_back('{4,   2,  5, -1, 3,  1, 2});
    vecs.push_back('{5,  -1,  4,  6, 5,  0, 0});   // start pulsed while busy
    vecs.push_back('{15, -1,  2, -1, 12, 0, 0});   // clamped to NumHeads
    vecs.push_back('{0,  -1,  1,  1, 0,  0, 0});   // start during FINISH
    vecs.push_back('{12, 11,  3, -1, 12, 1, 11});
    vecs.push_back('{1,   0,  1, -1, 1,  1, 0});
    vecs.push_back('{2,   5,  2, -1, 2,  0, 0});   // error head beyond the run
    foreach (vecs[i]) run_case($sformatf("vec%0d", i), vecs[i]);

    reset_mid_run();

    for (int i = 0; i < 8; i++) begin
      int hc;
      int ea;
      hc = int'($urandom_range(0, NumHeads + 3));
      ea = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, NumHeads + 1));
      run_case($sformatf("rnd%0d", i), model(hc, ea, int'($urandom_range(1, 6)), -1));
    end

`ifdef MHA_TIMEOUT_EN
    timeout_case();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
